instr_fetch_ctrl: RTL
=====================

Name: instr_fetch_ctrl

Overview:
Sequencer between the multicycle MIPS core and the byte-wide instruction memory, which has one registered 8-bit read port and a 32-bit write port.
- Fetch side: assembles one 32-bit instruction from four consecutive byte reads.
- Loader side: shares the same memory port with a program loader that writes whole words at boot or debug.
- Sits between the core's fetch stage, the loader, and instr_memory.

Parameters:
ADDR_W, 6, byte-address width of instr_memory (64 bytes).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
fetch_req_i  in  1  core requests an instruction
fetch_pc_i  in  ADDR_W  byte address of the instruction; bits [1:0] ignored
fetch_flush_i  in  1  abort an in-flight fetch
fetch_ready_o  out  1  controller can accept a fetch this cycle
fetch_valid_o  out  1  one-cycle pulse: instr_o updated
instr_o  out  32  last completed instruction, little-endian
ld_valid_i  in  1  loader word-write request
ld_addr_i  in  ADDR_W  loader byte address; bits [1:0] ignored
ld_data_i  in  32  loader word
ld_ready_o  out  1  loader request accepted this cycle when ld_valid_i=1
mem_we_o  out  1  instr_memory write enable
mem_addr_o  out  ADDR_W  instr_memory address
mem_wd_o  out  32  instr_memory write data
mem_rdata_i  in  8  instr_memory registered byte output (valid 1 cycle after address)

Behaviour:
- Reset (async, rst_ni=0):
  - State IDLE, cnt=0, base=0.
  - Outputs: mem_we_o=0, mem_addr_o=0, mem_wd_o=0, instr_o=0, fetch_valid_o=0, fetch_ready_o=0, ld_ready_o=0.
  - Reset mid-operation drops any fetch or write instantly; nothing is retried.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - fetch_ready_o=1 and ld_ready_o=1 only in IDLE. mem_we_o=0, mem_addr_o=0.
  - If ld_valid_i: latch base={ld_addr_i[ADDR_W-1:2],2'b00} and wdata=ld_data_i, then go to WRITE. The loader wins a simultaneous fetch_req_i; the fetch stays pending because fetch_ready_o was not honoured.
  - Else if fetch_req_i: latch base={fetch_pc_i[ADDR_W-1:2],2'b00}, set cnt=0, go to READ.
- WRITE (1 cycle):
  - mem_we_o=1, mem_addr_o=base, mem_wd_o=wdata, then go to IDLE.
  - Throughput: one loader word per 2 cycles.
- READ:
  - mem_addr_o=base+min(cnt,3), mem_we_o=0. cnt increments each cycle, 0..4.
  - When cnt=k (k>=1), capture mem_rdata_i into shadow byte k-1 (bits [8k-1:8k-8]).
  - At cnt=4, go to DONE.
- DONE (1 cycle):
  - instr_o<=shadow, fetch_valid_o=1, then go to IDLE.
- Latency: fetch accepted in cycle 0, READ in cycles 1-5, fetch_valid_o high in cycle 6. Minimum repeat period is 7 cycles.
- instr_o holds its value until the next DONE; it never changes on flush or WRITE.
- fetch_flush_i:
  - In READ: return to IDLE next cycle, no fetch_valid_o, shadow discarded.
  - In DONE: the instruction is still delivered.
  - In IDLE or WRITE: ignored.
- Address arithmetic:
  - Computed modulo 2^ADDR_W. base is word-aligned, so base+3 never wraps.
  - pc=2^ADDR_W-4 reads the last word.
- fetch_pc_i and ld_addr_i are sampled only in the accepting IDLE cycle; changes later are ignored.
- mem_wd_o=0 whenever mem_we_o=0.

Decomposition:
- Shared package mips_mem_pkg holds:
  - fetch_state_e enum {IDLE, READ, WRITE, DONE}
  - BYTES_PER_WORD=4
  - INSTR_W=32
- No sub-module. Byte assembly is a 4-entry shift/indexed register inside the block, about 150 lines.

Test Plan:
- Memory model preloaded with the Fibonacci image (bytes 08 00 03 20 ... at address 0); fetch pc=0x00 -> fetch_valid_o pulse in cycle 6, instr_o=0x20030008, and mem_addr_o sequence 0,1,2,3,3.
- Fetch pc=0x0D (misaligned) -> reads 0x0C..0x0F, instr_o=0x10600004.
- ld_valid_i with addr=0x24, data=0xDEADBEEF, then fetch pc=0x24 -> one-cycle mem_we_o with mem_addr_o=0x24 and mem_wd_o=0xDEADBEEF; fetch returns 0xDEADBEEF.
- ld_valid_i and fetch_req_i asserted in the same IDLE cycle -> WRITE first with fetch_ready_o=0; fetch accepted 2 cycles later.
- Fetch pc=0x04, then flush at cnt=2 -> no fetch_valid_o, IDLE next cycle, instr_o keeps its previous value. Then pc=0x3C -> addresses 0x3C..0x3F.
- rst_ni dropped at cnt=3 -> all outputs 0 asynchronously; after release, a fetch of pc=0x08 returns 0x2005FFFF.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the instruction-memory side of the multicycle MIPS core.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } fetch_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned INSTR_W        = 32;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Sequences byte-wide instr_memory reads into 32-bit instruction fetches and
// interleaves whole-word writes from the program loader on the same port.
module instr_fetch_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               fetch_req_i,
  input  logic [ADDR_W-1:0]  fetch_pc_i,
  input  logic               fetch_flush_i,
  output logic               fetch_ready_o,
  output logic               fetch_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  input  logic               ld_valid_i,
  input  logic [ADDR_W-1:0]  ld_addr_i,
  input  logic [INSTR_W-1:0] ld_data_i,
  output logic               ld_ready_o,
  output logic               mem_we_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic [INSTR_W-1:0] mem_wd_o,
  input  logic [7:0]         mem_rdata_i
);

  fetch_state_e                    state_q, state_d;
  logic [2:0]                      cnt_q, cnt_d;
  logic [ADDR_W-3:0]               base_q, base_d;
  logic [INSTR_W-1:0]              wdata_q, wdata_d;
  logic [INSTR_W-1:0]              instr_q, instr_d;
  logic [BYTES_PER_WORD-2:0][7:0]  shadow_q, shadow_d;
  logic [1:0]                      rd_off;
  logic                            unused_addr_lsbs;

  // Byte offset saturates at 3: the fifth READ cycle only collects the last byte.
  assign rd_off           = cnt_q[2] ? 2'd3 : cnt_q[1:0];
  assign instr_o          = instr_q;
  assign unused_addr_lsbs = ^{fetch_pc_i[1:0], ld_addr_i[1:0]};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    instr_d       = instr_q;
    shadow_d      = shadow_q;
    fetch_ready_o = 1'b0;
    ld_ready_o    = 1'b0;
    fetch_valid_o = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wd_o      = '0;

    unique case (state_q)
      IDLE: begin
        fetch_ready_o = rst_ni;
        ld_ready_o    = rst_ni;
        if (ld_valid_i) begin
          base_d  = ld_addr_i[ADDR_W-1:2];
          wdata_d = ld_data_i;
          state_d = WRITE;
        end else if (fetch_req_i) begin
          base_d  = fetch_pc_i[ADDR_W-1:2];
          cnt_d   = '0;
          state_d = READ;
        end
      end
      WRITE: begin
        mem_we_o   = 1'b1;
        mem_addr_o = {base_q, 2'b00};
        mem_wd_o   = wdata_q;
        state_d    = IDLE;
      end
      READ: begin
        mem_addr_o = {base_q, rd_off};
        if (fetch_flush_i) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
          unique case (cnt_q)
            3'd1: shadow_d[0] = mem_rdata_i;
            3'd2: shadow_d[1] = mem_rdata_i;
            3'd3: shadow_d[2] = mem_rdata_i;
            // The top byte goes straight into instr so it is already valid
            // during the DONE cycle that carries the fetch_valid_o pulse.
            3'd4: begin
              instr_d = {mem_rdata_i, shadow_q};
              state_d = DONE;
            end
            default: ;
          endcase
        end
      end
      DONE: begin
        fetch_valid_o = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      instr_q  <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      instr_q  <= instr_d;
      shadow_q <= shadow_d;
    end
  end

endmodule
